pattern_cmd_ctrl: RTL and testbench
===================================

Name: pattern_cmd_ctrl

Overview:
- Command sequencer between the UART receive byte stream and the pattern search engine.
- Decodes a one-byte command protocol and routes payload bytes as follows:
  - load-pattern payload becomes golden-word writes (golden_word / golden_word_valid / golden_word_index);
  - search-mode payload becomes character strobes (char_in / char_valid).
- Latches the engine's info output for the seven-segment display and counts results.
- Sits between uart_rx edge detection and pattern_search in the top level.

Parameters:
- N_BITS, 8, byte width of UART data, golden words and chars.
- PATTERN_SIZE, 10, number of golden-word bytes in one load command.
- IDX_W, $clog2(PATTERN_SIZE), width of golden_word_index (4 at default).
- TIMEOUT_CYCLES, 25_000_000, idle cycles allowed between load payload bytes before abort.
- CMD_LOAD, 8'h01, command byte that starts a pattern load.
- CMD_SEARCH, 8'h02, command byte that enters search mode.
- CMD_END, 8'h1B, byte that leaves search mode.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- byte_in  input  N_BITS  received UART byte.
- byte_valid  input  1  single-cycle strobe, byte_in valid.
- golden_word  output  N_BITS  pattern byte to engine.
- golden_word_valid  output  1  single-cycle write strobe.
- golden_word_index  output  IDX_W  write address, 0..PATTERN_SIZE-1.
- char_out  output  N_BITS  search character to engine.
- char_valid  output  1  single-cycle character strobe.
- info_data  input  N_BITS  engine result byte.
- info_valid  input  1  engine result strobe.
- disp_data  output  N_BITS  last latched info_data, drives display.
- info_count  output  8  number of info_valid strobes, saturates at 255.
- state_o  output  2  current state: 0 IDLE, 1 LOAD, 2 SEARCH.
- load_done  output  1  single-cycle pulse, full pattern written.
- err  output  1  single-cycle pulse on unknown command or load timeout.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state IDLE;
  - all strobes 0, golden_word_index 0, golden_word 0, char_out 0;
  - disp_data 0, info_count 0, timeout counter 0.
- Reset asserted mid-load or mid-search aborts immediately; no partial pulse is emitted after release.
- All outputs are registered. Every response to byte_valid appears exactly 1 cycle after the strobe cycle.
- IDLE, on byte_valid:
  - CMD_LOAD -> LOAD, write index counter cleared to 0.
  - CMD_SEARCH -> SEARCH.
  - CMD_END -> ignored, stay IDLE, no err.
  - any other byte -> err pulse, stay IDLE.
  - No golden_word_valid or char_valid is issued in IDLE.
- LOAD, on byte_valid:
  - Every byte value, including command and CMD_END values, is payload.
  - golden_word=byte_in, golden_word_index=counter, golden_word_valid=1 for one cycle, counter+1.
  - The byte written at index PATTERN_SIZE-1 also pulses load_done in the same cycle as its golden_word_valid, and the next state is IDLE.
  - The counter never wraps past PATTERN_SIZE-1.
- LOAD timeout:
  - Counter counts clk cycles without byte_valid and is cleared on each byte.
  - On reaching TIMEOUT_CYCLES-1 without a byte: err pulse, state IDLE, index counter 0.
  - Earlier writes are not undone.
  - A byte arriving in the same cycle as expiry wins: it is written and the timeout is cancelled.
- SEARCH, on byte_valid:
  - CMD_END -> IDLE, byte not forwarded.
  - Any other byte -> char_out=byte_in, char_valid=1 for one cycle.
  - No timeout in SEARCH.
- Info latch (any state):
  - info_valid -> disp_data<=info_data on the next edge; info_count+1, held at 255.
  - info_valid and byte_valid in the same cycle are handled independently; neither is dropped.
- Back-to-back byte_valid on consecutive cycles must be accepted without loss in every state.

Test Plan:
- Load: bytes 01, 41..4A (PATTERN_SIZE=10) -> 10 golden_word_valid pulses, index 0..9 with data 41..4A; load_done with index 9; state_o returns to 0.
- Search: 02, 61, 62, 1B, 63 -> char_valid for 61 and 62 only; state_o 2 then 0; 63 gives err.
- Timeout: TIMEOUT_CYCLES=100; send 01, 41, 42, then idle 100 cycles -> err pulse, state_o=0, no load_done. A following 01 restarts at index 0.
- Unknown and control bytes: 7F in IDLE -> err, state_o stays 0; 1B in IDLE -> no err.
- Info latch: info_valid with 35, then 07 -> disp_data 35 then 07, info_count 2. 300 strobes -> info_count 255.
- Reset mid-load: 01, 41, 42 then rst for 1 cycle -> all outputs 0 immediately. Next 01, 50.. load starts at index 0.

Source files
------------

// File: rtl/pattern_cmd_ctrl.sv
// pattern_cmd_ctrl
//   Command sequencer between the UART byte stream and the pattern search
//   engine. Decodes one-byte commands, turns load payload into golden-word
//   writes and search payload into character strobes, and latches engine
//   results for the display.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a command byte
//   LOAD  | next PATTERN_SIZE bytes are golden words; aborts on timeout
//   SEARCH| bytes forwarded as chars until CMD_END
//
// Ports
//   clk, rst                      : system clock, async active-high reset
//   byte_in, byte_valid           : received UART byte and its strobe
//   golden_word/_valid/_index     : pattern write port to the engine
//   char_out, char_valid          : search character port to the engine
//   info_data, info_valid         : engine result input
//   disp_data, info_count         : latched result, saturating result count
//   state_o, load_done, err       : status (0 IDLE, 1 LOAD, 2 SEARCH)
module pattern_cmd_ctrl #(
    parameter int          N_BITS         = 8,
    parameter int          PATTERN_SIZE   = 10,
    parameter int          IDX_W          = $clog2(PATTERN_SIZE),
    parameter int          TIMEOUT_CYCLES = 25_000_000,
    parameter logic [7:0]  CMD_LOAD       = 8'h01,
    parameter logic [7:0]  CMD_SEARCH     = 8'h02,
    parameter logic [7:0]  CMD_END        = 8'h1B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] byte_in,
    input  logic              byte_valid,
    output logic [N_BITS-1:0] golden_word,
    output logic              golden_word_valid,
    output logic [IDX_W-1:0]  golden_word_index,
    output logic [N_BITS-1:0] char_out,
    output logic              char_valid,
    input  logic [N_BITS-1:0] info_data,
    input  logic              info_valid,
    output logic [N_BITS-1:0] disp_data,
    output logic [7:0]        info_count,
    output logic [1:0]        state_o,
    output logic              load_done,
    output logic              err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_SIZE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] wr_idx;
    logic [TMO_W-1:0] tmo_cnt;

    // Command bytes are compared in their low byte so N_BITS may exceed 8.
    logic [7:0] cmd_byte;
    assign cmd_byte = byte_in[7:0];

    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            wr_idx            <= '0;
            tmo_cnt           <= '0;
            golden_word       <= '0;
            golden_word_valid <= 1'b0;
            golden_word_index <= '0;
            char_out          <= '0;
            char_valid        <= 1'b0;
            load_done         <= 1'b0;
            err               <= 1'b0;
        end else begin
            golden_word_valid <= 1'b0;
            char_valid        <= 1'b0;
            load_done         <= 1'b0;
            err               <= 1'b0;

            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (byte_valid) begin
                        if (cmd_byte == CMD_LOAD) begin
                            state  <= S_LOAD;
                            wr_idx <= '0;
                        end else if (cmd_byte == CMD_SEARCH) begin
                            state <= S_SEARCH;
                        end else if (cmd_byte != CMD_END) begin
                            err <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    // A byte in the expiry cycle takes priority over the timeout.
                    if (byte_valid) begin
                        golden_word       <= byte_in;
                        golden_word_index <= wr_idx;
                        golden_word_valid <= 1'b1;
                        tmo_cnt           <= '0;
                        if (wr_idx == IDX_LAST) begin
                            load_done <= 1'b1;
                            state     <= S_IDLE;
                            wr_idx    <= '0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err     <= 1'b1;
                        state   <= S_IDLE;
                        wr_idx  <= '0;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_SEARCH: begin
                    tmo_cnt <= '0;
                    if (byte_valid) begin
                        if (cmd_byte == CMD_END) begin
                            state <= S_IDLE;
                        end else begin
                            char_out   <= byte_in;
                            char_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    wr_idx  <= '0;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

    // Result latch runs independently of the command FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data  <= '0;
            info_count <= '0;
        end else if (info_valid) begin
            disp_data <= info_data;
            if (info_count != 8'hFF) begin
                info_count <= info_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_cmd_ctrl.sv
module tb_pattern_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] golden_word;
    logic       golden_word_valid;
    logic [3:0] golden_word_index;
    logic [7:0] char_out;
    logic       char_valid;
    logic [7:0] info_data;
    logic       info_valid;
    logic [7:0] disp_data;
    logic [7:0] info_count;
    logic [1:0] state_o;
    logic       load_done;
    logic       err;

    int checks = 0;
    int errors = 0;

    pattern_cmd_ctrl #(
        .N_BITS         (8),
        .PATTERN_SIZE   (10),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .byte_in           (byte_in),
        .byte_valid        (byte_valid),
        .golden_word       (golden_word),
        .golden_word_valid (golden_word_valid),
        .golden_word_index (golden_word_index),
        .char_out          (char_out),
        .char_valid        (char_valid),
        .info_data         (info_data),
        .info_valid        (info_valid),
        .disp_data         (disp_data),
        .info_count        (info_count),
        .state_o           (state_o),
        .load_done         (load_done),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one byte strobe; returns just after the capturing edge so the
    // registered response is visible. Consecutive calls give back-to-back strobes.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_info(input logic [7:0] d);
        @(negedge clk);
        info_data  = d;
        info_valid = 1'b1;
        @(posedge clk);
        #1;
        info_valid = 1'b0;
    endtask

    initial begin
        int first_err;
        bit saw_done;

        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        info_data  = 8'h00;
        info_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_state", state_o, 0);
        check_val("rst_gwv", golden_word_valid, 0);
        check_val("rst_idx", golden_word_index, 0);
        check_val("rst_disp", disp_data, 0);
        check_val("rst_cnt", info_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full pattern load, back-to-back payload
        send_byte(8'h01);
        check_val("load_enter", state_o, 1);
        check_val("load_enter_gwv", golden_word_valid, 0);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h41 + 8'(i));
            check_val("load_gwv", golden_word_valid, 1);
            check_val("load_idx", golden_word_index, 32'(i));
            check_val("load_data", golden_word, 32'h41 + 32'(i));
            check_val("load_done", load_done, (i == 9) ? 1 : 0);
            check_val("load_state", state_o, (i == 9) ? 0 : 1);
        end
        @(posedge clk);
        #1;
        check_val("load_done_single", load_done, 0);

        // Search mode
        send_byte(8'h02);
        check_val("srch_enter", state_o, 2);
        send_byte(8'h61);
        check_val("srch_cv_61", char_valid, 1);
        check_val("srch_ch_61", char_out, 8'h61);
        send_byte(8'h62);
        check_val("srch_cv_62", char_valid, 1);
        check_val("srch_ch_62", char_out, 8'h62);
        send_byte(8'h1B);
        check_val("srch_end_cv", char_valid, 0);
        check_val("srch_end_state", state_o, 0);
        send_byte(8'h63);
        check_val("idle_63_err", err, 1);
        check_val("idle_63_cv", char_valid, 0);

        // Unknown and control bytes in IDLE
        send_byte(8'h7F);
        check_val("idle_7f_err", err, 1);
        check_val("idle_7f_state", state_o, 0);
        send_byte(8'h1B);
        check_val("idle_1b_err", err, 0);
        check_val("idle_1b_state", state_o, 0);

        // Load timeout: error expected exactly 100 idle edges after last byte
        send_byte(8'h01);
        send_byte(8'h41);
        send_byte(8'h42);
        check_val("tmo_idx1", golden_word_index, 1);
        first_err = 0;
        saw_done  = 1'b0;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk);
            #1;
            if (load_done) saw_done = 1'b1;
            if (err && first_err == 0) first_err = i;
        end
        check_val("tmo_cycle", first_err, 100);
        check_val("tmo_no_done", saw_done, 0);
        check_val("tmo_state", state_o, 0);
        send_byte(8'h01);
        send_byte(8'h50);
        check_val("tmo_restart_idx", golden_word_index, 0);
        check_val("tmo_restart_gwv", golden_word_valid, 1);

        // Reset mid-load: asynchronous clear, then restart from index 0
        send_byte(8'h51);
        check_val("pre_rst_idx", golden_word_index, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("arst_state", state_o, 0);
        check_val("arst_gwv", golden_word_valid, 0);
        check_val("arst_idx", golden_word_index, 0);
        check_val("arst_gw", golden_word, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_gwv", golden_word_valid, 0);
        send_byte(8'h01);
        check_val("rst_reload_state", state_o, 1);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h50 + 8'(i));
            if (i == 0) check_val("rst_reload_idx0", golden_word_index, 0);
        end
        check_val("rst_reload_done", load_done, 1);
        check_val("rst_reload_last", golden_word_index, 9);

        // Info latch
        send_info(8'h35);
        check_val("info_disp_35", disp_data, 8'h35);
        check_val("info_cnt_1", info_count, 1);
        send_info(8'h07);
        check_val("info_disp_07", disp_data, 8'h07);
        check_val("info_cnt_2", info_count, 2);

        // info_valid and byte_valid in the same cycle
        @(negedge clk);
        byte_in    = 8'h02;
        byte_valid = 1'b1;
        info_data  = 8'h99;
        info_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        info_valid = 1'b0;
        check_val("both_state", state_o, 2);
        check_val("both_disp", disp_data, 8'h99);
        check_val("both_cnt", info_count, 3);
        send_byte(8'h1B);

        // Saturation: 300 more strobes from count 3
        @(negedge clk);
        info_data  = 8'hA5;
        info_valid = 1'b1;
        repeat (251) @(negedge clk);
        check_val("info_cnt_254", info_count, 254);
        repeat (49) @(negedge clk);
        info_valid = 1'b0;
        #1;
        check_val("info_sat", info_count, 255);
        check_val("info_sat_disp", disp_data, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
